// File: rtl/irq_priority_ctrl_if.sv
// irq_priority_ctrl_if
// Groups the request/enable/opcode inputs of the interrupt controller and
// its issue outputs toward jump control.
//   master : the pipeline side (drives requests, masks, opcode; sees issue)
//   slave  : the controller itself
// Signals:
//   irq[3:0]          level request lines, rising edge makes a request
//   irq_mask[3:0]     per-source enable, 1 = eligible
//   global_en         master enable for issue
//   op[5:0]           opcode currently in execute
//   interrupt         one-cycle pulse to jump control
//   vec_address[15:0] handler address, held between issues
//   irq_ack[3:0]      one-hot pulse coincident with interrupt
//   in_service        a handler is active
//   active_id[1:0]    source currently in service
interface irq_priority_ctrl_if;
  logic [3:0]  irq;
  logic [3:0]  irq_mask;
  logic        global_en;
  logic [5:0]  op;
  logic        interrupt;
  logic [15:0] vec_address;
  logic [3:0]  irq_ack;
  logic        in_service;
  logic [1:0]  active_id;

  modport master (
    output irq, irq_mask, global_en, op,
    input  interrupt, vec_address, irq_ack, in_service, active_id
  );

  modport slave (
    input  irq, irq_mask, global_en, op,
    output interrupt, vec_address, irq_ack, in_service, active_id
  );
endinterface

// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl
// Latches edge-triggered requests from four sources, issues the lowest-index
// eligible one to jump control as a single-cycle interrupt pulse with its
// vector address, then waits for the return-from-interrupt opcode.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    irq_priority_ctrl_if.slave (requests, masks, opcode, issue outputs)
// Build option:
//   NESTED_IRQ_EN  when defined, a strictly higher-priority source preempts
//                  an active handler; preempted ids go on a 4-entry stack.
//
// state   | meaning
// IDLE    | no handler active, waiting for an eligible source
// ISSUE   | one cycle: interrupt/irq_ack pulse, vector valid
// SERVICE | handler running, waiting for RETI
module irq_priority_ctrl #(
  parameter logic [15:0] VEC_BASE   = 16'h0100,
  parameter logic [15:0] VEC_STRIDE = 16'h0004,
  parameter logic [5:0]  RETI_OP    = 6'h1e
) (
  input logic clk,
  input logic reset,
  irq_priority_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t      state, next_state;
  logic [3:0]  irq_q, pend, pend_nxt, eligible, win_oh;
  logic [1:0]  win_id;
  logic [15:0] vector;
  logic        take, reti;

`ifdef NESTED_IRQ_EN
  logic [1:0] id_stack [0:3];
  logic [2:0] sp;
  logic       push, pop;
`endif

  assign reti     = (bus.op == RETI_OP);
  assign eligible = pend & bus.irq_mask & {4{bus.global_en}};
  assign win_oh   = 4'b0001 << win_id;
  assign vector   = VEC_BASE + VEC_STRIDE * {14'd0, win_id};

  always_comb begin
    win_id = 2'd0;
    if (eligible[0])      win_id = 2'd0;
    else if (eligible[1]) win_id = 2'd1;
    else if (eligible[2]) win_id = 2'd2;
    else if (eligible[3]) win_id = 2'd3;
  end

  // A new edge on the bit being issued wins over the issue clear.
  always_comb begin
    pend_nxt = pend;
    if (state == ISSUE) pend_nxt[bus.active_id] = 1'b0;
    pend_nxt = pend_nxt | (bus.irq & ~irq_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    take       = 1'b0;
`ifdef NESTED_IRQ_EN
    push       = 1'b0;
    pop        = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|eligible) begin
          next_state = ISSUE;
          take       = 1'b1;
        end
      end
      ISSUE: next_state = SERVICE;
      SERVICE: begin
`ifdef NESTED_IRQ_EN
        // RETI is handled first so a handler exit is never lost to a
        // simultaneous preemption; the preemption is re-evaluated next cycle.
        if (reti) begin
          if (sp != 3'd0) pop = 1'b1;
          else            next_state = IDLE;
        end else if ((|eligible) && (win_id < bus.active_id)) begin
          next_state = ISSUE;
          take       = 1'b1;
          push       = 1'b1;
        end
`else
        if (reti) next_state = IDLE;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef NESTED_IRQ_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= 3'd0;
      for (int i = 0; i < 4; i++) id_stack[i] <= 2'd0;
    end else if (push) begin
      id_stack[sp[1:0]] <= bus.active_id;
      sp                <= sp + 3'd1;
    end else if (pop) begin
      sp <= sp - 3'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q           <= 4'b0;
      pend            <= 4'b0;
      bus.interrupt   <= 1'b0;
      bus.irq_ack     <= 4'b0;
      bus.vec_address <= 16'h0000;
      bus.in_service  <= 1'b0;
      bus.active_id   <= 2'd0;
    end else begin
      irq_q          <= bus.irq;
      pend           <= pend_nxt;
      bus.interrupt  <= take;
      bus.irq_ack    <= take ? win_oh : 4'b0;
      // A preempting issue keeps in_service high through its ISSUE cycle.
      bus.in_service <= (next_state == SERVICE) ||
                        ((state == SERVICE) && (next_state == ISSUE));
      if (take) begin
        bus.vec_address <= vector;
        bus.active_id   <= win_id;
      end
`ifdef NESTED_IRQ_EN
      else if (pop) begin
        bus.active_id <= id_stack[sp[1:0] - 2'd1];
      end
`endif
    end
  end

endmodule

// File: doc/irq_priority_ctrl.md
# irq_priority_ctrl

Interrupt controller that sits in front of the jump-control block in the MIPS pipeline. It latches edge-triggered requests from up to four sources, picks one by fixed priority, and drives the single-cycle `interrupt` pulse and the vector address into jump control. It then holds off further requests until the handler's return-from-interrupt opcode reaches execute.

## Interface
- `VEC_BASE`, 16'h0100, vector address of source 0
- `VEC_STRIDE`, 16'h0004, address spacing between consecutive source vectors
- `RETI_OP`, 6'h1e, opcode that ends a handler

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `irq`  in  4  level request lines, synchronous to `clk`; a rising edge makes a request
- `irq_mask`  in  4  per-source enable; 1 = eligible for issue
- `global_en`  in  1  master enable for issue
- `op`  in  6  opcode currently in execute (same field jump control decodes)
- `interrupt`  out  1  one-cycle pulse to jump control
- `vec_address`  out  16  handler address, valid while `interrupt` = 1, otherwise holds its last value
- `irq_ack`  out  4  one-hot pulse, coincident with `interrupt`
- `in_service`  out  1  a handler is active
- `active_id`  out  2  source currently in service

## Operation
- Edge detect: `irq_q` is `irq` delayed one clock.
  - `pend[i]` sets when `irq[i] & ~irq_q[i]`.
  - `pend[i]` clears when source i is issued.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Masked sources still latch pending. They become issuable once unmasked.
- Eligible = `pend & irq_mask`, gated by `global_en`. Fixed priority: lowest index wins.
- Vector = `VEC_BASE + id*VEC_STRIDE`, computed mod 2^16 (wraps, no saturation).
- FSM, 2-bit state register:
  - IDLE: if any source is eligible, go to ISSUE and latch the winner's id. `op == RETI_OP` is ignored.
  - ISSUE, one cycle:
    - `interrupt` = 1, `irq_ack[id]` = 1, `vec_address` = vector.
    - Clear `pend[id]` and go to SERVICE unconditionally. RETI in this cycle is ignored.
  - SERVICE:
    - `in_service` = 1. New edges keep latching.
    - `op == RETI_OP` returns to IDLE.
- Outputs in IDLE: `interrupt` = 0, `irq_ack` = 0, `in_service` = 0. `active_id` holds its last value.
- Reset values: `interrupt` = 0, `irq_ack` = 4'b0, `vec_address` = 16'h0000, `in_service` = 0, `active_id` = 2'd0, `pend` = 0, `irq_q` = 0, state = IDLE.
  - Because `irq_q` resets to 0, a line held high at reset release becomes pending in the first cycle.
- Reset mid-handler drops all pending requests and the service state immediately.

## Timing
- `irq` first sampled high at edge E0 → `pend` set after E0 → `interrupt` high after E1, for exactly one cycle. Latency is 2 clocks.
- ISSUE → SERVICE takes 1 clock. `in_service` rises the cycle after `interrupt`.
- RETI sampled at edge Er → IDLE after Er → the next `interrupt` comes no earlier than after Er+1.
- Back-to-back issues are therefore separated by at least 3 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `NESTED_IRQ_EN` defined:
  - In SERVICE, an eligible source with a strictly lower index than `active_id` preempts. The FSM goes to ISSUE, with the current id pushed onto a 4-entry id stack.
  - RETI pops the stack. `active_id` reverts to the popped id and the FSM stays in SERVICE.
  - RETI with the stack empty returns to IDLE.
  - `in_service` stays 1 until the stack empties.
  - Equal or lower priority requests wait.
  - The stack cannot overflow: each nesting level is strictly higher priority.
- `NESTED_IRQ_EN` undefined: no stack. SERVICE never issues.

## Test plan
- Reset low for 1 cycle with `irq` = 4'b0000, then release → all outputs at reset values, no `interrupt`.
- `irq[2]` rises, mask 4'hF, `global_en` = 1 → `interrupt` pulse 2 clocks later, `vec_address` = 16'h0108, `irq_ack` = 4'b0100, `active_id` = 2; `in_service` rises next cycle.
- `irq[3]` and `irq[1]` rise together → source 1 issued first (vec 16'h0104). After `op` = 6'h1e, source 3 issued (vec 16'h010C) 2 cycles after RETI.
- `irq[0]` rises with `irq_mask[0]` = 0 → no issue. Setting the mask bit 10 cycles later → issue 1 cycle after unmask, vec 16'h0100.
- In SERVICE for source 2, `irq[0]` rises:
  - With `NESTED_IRQ_EN`: preempt, vec 16'h0100. First RETI → `active_id` = 2, `in_service` = 1. Second RETI → IDLE.
  - Without `NESTED_IRQ_EN`: source 0 issued only after RETI.
- Reset asserted during SERVICE with `irq[1]` pending → `pend` cleared, `in_service` = 0 asynchronously, no issue after release unless a new edge arrives.
